// File: rtl/sfx_pkg.sv
// Shared constants for the sound-effect arbiter: note codes, source encodings,
// sequence lengths and the effect sequence lookup.
package sfx_pkg;

  localparam logic [11:0] C4 = 12'd262;
  localparam logic [11:0] E4 = 12'd330;
  localparam logic [11:0] G4 = 12'd392;
  localparam logic [11:0] C5 = 12'd523;
  localparam logic [11:0] E5 = 12'd659;
  localparam logic [11:0] G5 = 12'd784;
  localparam logic [11:0] C6 = 12'd1047;

  localparam int LEN_DEAD = 4;
  localparam int LEN_JUMP = 2;
  localparam int LEN_DUCK = 1;

  // Encoding doubles as priority: a larger value wins.
  typedef enum logic [1:0] {
    SRC_BGM  = 2'd0,
    SRC_DUCK = 2'd1,
    SRC_JUMP = 2'd2,
    SRC_DEAD = 2'd3
  } src_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_e;

  function automatic logic [11:0] seq_note(input src_e src, input logic [1:0] idx);
    logic [11:0] note;
    note = '0;
    case (src)
      SRC_DEAD: begin
        case (idx)
          2'd0:    note = C6;
          2'd1:    note = G5;
          2'd2:    note = E5;
          default: note = C5;
        endcase
      end
      SRC_JUMP: note = (idx == 2'd0) ? C5 : G5;
      SRC_DUCK: note = G4;
      default:  note = '0;
    endcase
    return note;
  endfunction

  function automatic logic [1:0] seq_last(input src_e src);
    logic [1:0] last;
    case (src)
      SRC_DEAD: last = 2'(LEN_DEAD - 1);
      SRC_JUMP: last = 2'(LEN_JUMP - 1);
      SRC_DUCK: last = 2'(LEN_DUCK - 1);
      default:  last = 2'd0;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/sfx_tick_gen.sv
// Effect-tick prescaler: counts 0..TICK_DIV-1 and pulses tick for one cycle on
// the last count; clr restarts the count so a newly loaded note gets a full hold.
module sfx_tick_gen #(
  parameter int TICK_DIV = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) cnt_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sfx_arbiter.sv
// Sound-effect arbiter: edge-triggered effect requests preempt background music
// by priority and play fixed note sequences with registered outputs.
module sfx_arbiter
  import sfx_pkg::*;
#(
  parameter int TICK_DIV   = 5_000_000,
  parameter int NOTE_TICKS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        req_dead,
  input  logic        req_jump,
  input  logic        req_duck,
  input  logic [11:0] bgm_note_1,
  input  logic [11:0] bgm_note_2,
  output logic [11:0] note_1,
  output logic [11:0] note_2,
  output logic        busy,
  output logic [1:0]  active_src
);

  localparam int NTW = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
  localparam logic [NTW-1:0] LAST_TICK = NTW'(NOTE_TICKS - 1);

  logic [2:0]     req_vec, trig;
  logic [2:0]     prev_q, prev_d;
  logic [2:0]     arm_q, arm_d;
  state_e         state_q, state_d;
  src_e           src_q, src_d, trig_src;
  logic [1:0]     idx_q, idx_d;
  logic [NTW-1:0] ntick_q, ntick_d;
  logic [11:0]    note_1_q, note_1_d, note_2_q, note_2_d;
  logic           busy_q, busy_d;
  logic [1:0]     active_src_q, active_src_d;
  logic           load, tick;

  assign req_vec = {req_dead, req_jump, req_duck};
  assign prev_d  = req_vec;
  // A request high during reset stays disarmed until it is seen low.
  assign arm_d   = rst ? ~req_vec : (arm_q | ~req_vec);
  assign trig    = req_vec & ~prev_q & arm_q;

  sfx_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (load),
    .tick (tick)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    trig_src = SRC_BGM;
    if      (trig[2]) trig_src = SRC_DEAD;
    else if (trig[1]) trig_src = SRC_JUMP;
    else if (trig[0]) trig_src = SRC_DUCK;
  end

  assign load = (trig_src != SRC_BGM) && ((state_q == ST_IDLE) || (trig_src >= src_q));

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    idx_d   = idx_q;
    ntick_d = ntick_q;
    if (load) begin
      state_d = ST_PLAY;
      src_d   = trig_src;
      idx_d   = 2'd0;
      ntick_d = '0;
    end else if (state_q == ST_PLAY && tick) begin
      if (ntick_q == LAST_TICK) begin
        ntick_d = '0;
        if (idx_q == seq_last(src_q)) begin
          state_d = ST_IDLE;
          src_d   = SRC_BGM;
          idx_d   = 2'd0;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end else begin
        ntick_d = ntick_q + NTW'(1);
      end
    end
  end

  // Outputs are decoded from next state so the first note appears right after the trigger edge.
  always_comb begin
    note_1_d     = en ? bgm_note_1 : 12'd0;
    note_2_d     = en ? bgm_note_2 : 12'd0;
    busy_d       = 1'b0;
    active_src_d = SRC_BGM;
    if (state_d == ST_PLAY) begin
      note_1_d     = seq_note(src_d, idx_d);
      note_2_d     = note_1_d;
      busy_d       = 1'b1;
      active_src_d = src_d;
    end
  end

  always_ff @(posedge clk) begin
    arm_q <= arm_d;
    if (rst) begin
      prev_q       <= '0;
      state_q      <= ST_IDLE;
      src_q        <= SRC_BGM;
      idx_q        <= 2'd0;
      ntick_q      <= '0;
      note_1_q     <= '0;
      note_2_q     <= '0;
      busy_q       <= 1'b0;
      active_src_q <= SRC_BGM;
    end else begin
      prev_q       <= prev_d;
      state_q      <= state_d;
      src_q        <= src_d;
      idx_q        <= idx_d;
      ntick_q      <= ntick_d;
      note_1_q     <= note_1_d;
      note_2_q     <= note_2_d;
      busy_q       <= busy_d;
      active_src_q <= active_src_d;
    end
  end

  assign note_1     = note_1_q;
  assign note_2     = note_2_q;
  assign busy       = busy_q;
  assign active_src = active_src_q;

endmodule

// File: tb/tb_sfx_arbiter.sv
// Self-checking bench for sfx_arbiter with TICK_DIV=4, NOTE_TICKS=2 (8-cycle notes):
// vector table plus a hand-written reset/held-request sequence, checked via a scoreboard.
module tb_sfx_arbiter;

  localparam int TICK_DIV   = 4;
  localparam int NOTE_TICKS = 2;

  logic        clk = 1'b0;
  logic        rst, en, req_dead, req_jump, req_duck;
  logic [11:0] bgm_note_1, bgm_note_2, note_1, note_2;
  logic        busy;
  logic [1:0]  active_src;

  always #5 clk = ~clk;

  sfx_arbiter #(.TICK_DIV(TICK_DIV), .NOTE_TICKS(NOTE_TICKS)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req_dead   (req_dead),
    .req_jump   (req_jump),
    .req_duck   (req_duck),
    .bgm_note_1 (bgm_note_1),
    .bgm_note_2 (bgm_note_2),
    .note_1     (note_1),
    .note_2     (note_2),
    .busy       (busy),
    .active_src (active_src)
  );

  typedef struct {
    string       name;
    logic        rst, dead, jump, duck, en;
    int          cycles;
    logic [11:0] n1, n2;
    logic        busy;
    logic [1:0]  src;
  } vec_t;

  typedef struct {
    string       name;
    int          due;
    logic [11:0] n1, n2;
    logic        busy;
    logic [1:0]  src;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t cur;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, req);
    end
  endtask

  // Pop every expectation due at this cycle and compare against the registered outputs.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      cur = sb.pop_front();
      check({cur.name, " note_1"},     32'(note_1),     32'(cur.n1));
      check({cur.name, " note_2"},     32'(note_2),     32'(cur.n2));
      check({cur.name, " busy"},       32'(busy),       32'(cur.busy));
      check({cur.name, " active_src"}, 32'(active_src), 32'(cur.src));
    end
  end

  task automatic step(input string nm, input logic r, d, j, k, e,
                      input logic [11:0] n1, n2, input logic b, input logic [1:0] s);
    exp_t ex;
    rst = r; req_dead = d; req_jump = j; req_duck = k; en = e;
    ex.name = nm; ex.due = cyc + 1; ex.n1 = n1; ex.n2 = n2; ex.busy = b; ex.src = s;
    sb.push_back(ex);
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string nm, input logic r, d, j, k, e, input int n,
                     input logic [11:0] n1, n2, input logic b, input logic [1:0] s);
    vec_t v;
    v.name = nm; v.rst = r; v.dead = d; v.jump = j; v.duck = k; v.en = e;
    v.cycles = n; v.n1 = n1; v.n2 = n2; v.busy = b; v.src = s;
    vecs.push_back(v);
  endtask

  task automatic play(input string nm, input logic d, j, k, e, input int n,
                      input logic [11:0] note, input logic [1:0] s);
    add(nm, 1'b0, d, j, k, e, n, note, note, 1'b1, s);
  endtask

  // Idle with background music 440/220 when enabled, silence otherwise.
  task automatic idle(input string nm, input logic e, input int n);
    add(nm, 1'b0, 1'b0, 1'b0, 1'b0, e, n, e ? 12'd440 : 12'd0, e ? 12'd220 : 12'd0, 1'b0, 2'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; req_dead = 1'b0; req_jump = 1'b0; req_duck = 1'b0;
    bgm_note_1 = 12'd440; bgm_note_2 = 12'd220;
    @(posedge clk);
    #1;

    add("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2, 12'd0, 12'd0, 1'b0, 2'd0);
    idle("bgm on", 1'b1, 2);
    idle("en low", 1'b0, 2);
    idle("en high", 1'b1, 1);
    // Single jump: 8 cycles of 523, 8 of 784, back to bgm.
    play("jump trig", 0, 1, 0, 1, 1, 12'd523, 2'd2);
    play("jump n0",   0, 0, 0, 1, 7, 12'd523, 2'd2);
    play("jump n1",   0, 0, 0, 1, 8, 12'd784, 2'd2);
    idle("jump done", 1'b1, 2);
    // Duck during jump note 0 is dropped; jump timing unchanged.
    play("j2 trig",   0, 1, 0, 1, 1, 12'd523, 2'd2);
    play("j2 n0a",    0, 0, 0, 1, 2, 12'd523, 2'd2);
    play("duck ign",  0, 0, 1, 1, 1, 12'd523, 2'd2);
    play("j2 n0b",    0, 0, 0, 1, 4, 12'd523, 2'd2);
    play("j2 n1",     0, 0, 0, 1, 8, 12'd784, 2'd2);
    idle("j2 done", 1'b1, 1);
    // Dead preempts jump and plays its full 32 cycles.
    play("j3 trig",   0, 1, 0, 1, 1, 12'd523, 2'd2);
    play("j3 n0",     0, 0, 0, 1, 3, 12'd523, 2'd2);
    play("dead pre",  1, 0, 0, 1, 1, 12'd1047, 2'd3);
    play("dead n0",   0, 0, 0, 1, 7, 12'd1047, 2'd3);
    play("dead n1",   0, 0, 0, 1, 8, 12'd784, 2'd3);
    play("dead n2",   0, 0, 0, 1, 8, 12'd659, 2'd3);
    play("dead n3",   0, 0, 0, 1, 8, 12'd523, 2'd3);
    idle("dead done", 1'b1, 1);
    // Simultaneous dead and jump: only dead plays.
    play("dj trig",   1, 1, 0, 1, 1, 12'd1047, 2'd3);
    play("dj n0",     0, 0, 0, 1, 7, 12'd1047, 2'd3);
    play("dj n1",     0, 0, 0, 1, 8, 12'd784, 2'd3);
    play("dj n2",     0, 0, 0, 1, 8, 12'd659, 2'd3);
    play("dj n3",     0, 0, 0, 1, 8, 12'd523, 2'd3);
    idle("dj done", 1'b1, 2);
    // Jump retriggered during note 1 restarts with a fresh hold.
    play("rj trig",   0, 1, 0, 1, 1, 12'd523, 2'd2);
    play("rj n0",     0, 0, 0, 1, 7, 12'd523, 2'd2);
    play("rj n1",     0, 0, 0, 1, 3, 12'd784, 2'd2);
    play("rj re",     0, 1, 0, 1, 1, 12'd523, 2'd2);
    play("rj re n0",  0, 0, 0, 1, 7, 12'd523, 2'd2);
    play("rj re n1",  0, 0, 0, 1, 8, 12'd784, 2'd2);
    idle("rj done", 1'b1, 1);
    // Effects play with en=0; idle stays silent.
    play("duck en0",  0, 0, 1, 0, 1, 12'd392, 2'd1);
    play("duck n0",   0, 0, 0, 0, 7, 12'd392, 2'd1);
    idle("duck done", 1'b0, 2);
    idle("en back", 1'b1, 1);

    for (int i = 0; i < vecs.size(); i++)
      for (int c = 0; c < vecs[i].cycles; c++)
        step(vecs[i].name, vecs[i].rst, vecs[i].dead, vecs[i].jump, vecs[i].duck,
             vecs[i].en, vecs[i].n1, vecs[i].n2, vecs[i].busy, vecs[i].src);

    // Reset during dead note 2 with req_dead held high across reset.
    step("rd trig", 0, 1, 0, 0, 1, 12'd1047, 12'd1047, 1, 2'd3);
    repeat (7) step("rd n0", 0, 0, 0, 0, 1, 12'd1047, 12'd1047, 1, 2'd3);
    repeat (8) step("rd n1", 0, 0, 0, 0, 1, 12'd784, 12'd784, 1, 2'd3);
    repeat (2) step("rd n2", 0, 0, 0, 0, 1, 12'd659, 12'd659, 1, 2'd3);
    repeat (2) step("rd reset", 1, 1, 0, 0, 1, 12'd0, 12'd0, 0, 2'd0);
    repeat (3) step("rd held", 0, 1, 0, 0, 1, 12'd440, 12'd220, 0, 2'd0);
    step("rd low", 0, 0, 0, 0, 1, 12'd440, 12'd220, 0, 2'd0);
    step("rd retrig", 0, 1, 0, 0, 1, 12'd1047, 12'd1047, 1, 2'd3);
    repeat (7) step("rd2 n0", 0, 0, 0, 0, 1, 12'd1047, 12'd1047, 1, 2'd3);
    repeat (8) step("rd2 n1", 0, 0, 0, 0, 1, 12'd784, 12'd784, 1, 2'd3);
    repeat (8) step("rd2 n2", 0, 0, 0, 0, 1, 12'd659, 12'd659, 1, 2'd3);
    repeat (8) step("rd2 n3", 0, 0, 0, 0, 1, 12'd523, 12'd523, 1, 2'd3);
    step("rd2 done", 0, 0, 0, 0, 1, 12'd440, 12'd220, 0, 2'd0);

    // Background notes are registered: a new value shows one cycle later.
    bgm_note_1 = 12'd1000;
    bgm_note_2 = 12'd50;
    step("bgm change", 0, 0, 0, 0, 1, 12'd1000, 12'd50, 0, 2'd0);

    repeat (2) @(negedge clk);
    #1;
    check("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
